// File: rtl/tlul_pkg.sv
// TL-UL bus types and the register-adapter state encoding shared by
// the adapter, its interface and its legality checker.
package tlul_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_DBW = TL_DW / 8;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_SZW = 2;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  // Opcode fields are plain vectors so that illegal encodings can be carried.
  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic              d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } reg_adp_state_e;

endpackage

// File: rtl/tlul_adapter_reg_if.sv
// TL-UL link between a host (master) and the register adapter (slave).
interface tlul_adapter_reg_if;

  tlul_pkg::tl_h2d_t tl_i;
  tlul_pkg::tl_d2h_t tl_o;

  modport slave  (input tl_i, output tl_o);
  modport master (output tl_i, input tl_o);

endinterface

// File: rtl/tlul_req_check.sv
// Combinational legality check of an A-channel request.
module tlul_req_check
  import tlul_pkg::*;
(
  input  logic [2:0]        opcode,
  input  logic [TL_SZW-1:0] size,
  input  logic [1:0]        addr_lo,
  input  logic [TL_DBW-1:0] mask,
  output logic              illegal
);

  logic op_ok;
  logic is_put;
  logic size_ok;
  logic align_ok;
  logic mask_ok;

  always_comb begin
    op_ok   = opcode inside {Get, PutFullData, PutPartialData};
    is_put  = (opcode == PutFullData) || (opcode == PutPartialData);
    size_ok = (size <= TL_SZW'(2));
    unique case (size)
      2'd0:    align_ok = 1'b1;
      2'd1:    align_ok = !addr_lo[0];
      2'd2:    align_ok = (addr_lo == 2'b00);
      default: align_ok = 1'b0;
    endcase
    // A full-word PutFull must write every byte lane.
    mask_ok = !(is_put && (mask == '0)) &&
              !((opcode == PutFullData) && (size == TL_SZW'(2)) && (mask != '1));
    illegal = !(op_ok && size_ok && align_ok && mask_ok);
  end

endmodule

// File: rtl/tlul_adapter_reg.sv
// TL-UL device responder driving a simple register bus, one request outstanding.
// Optional REQ-state timeout enabled by defining TLUL_ADAPTER_TIMEOUT_EN.
module tlul_adapter_reg
  import tlul_pkg::*;
#(
  parameter int unsigned REG_AW      = 8,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  tlul_adapter_reg_if.slave   tl,
  output logic                re_o,
  output logic                we_o,
  output logic [REG_AW-1:0]   addr_o,
  output logic [TL_DW-1:0]    wdata_o,
  output logic [TL_DBW-1:0]   be_o,
  input  logic [TL_DW-1:0]    rdata_i,
  input  logic                ack_i,
  input  logic                err_i
);

  reg_adp_state_e    state;
  logic              is_get;
  logic [2:0]        d_opcode;
  logic [TL_SZW-1:0] d_size;
  logic [TL_AIW-1:0] d_source;
  logic [TL_DW-1:0]  d_data;
  logic              d_error;
  logic              illegal;
  logic              a_ready;
  logic              accept;

  tlul_req_check u_req_check (
    .opcode  (tl.tl_i.a_opcode),
    .size    (tl.tl_i.a_size),
    .addr_lo (tl.tl_i.a_address[1:0]),
    .mask    (tl.tl_i.a_mask),
    .illegal (illegal)
  );

  assign a_ready = rst_ni && (state == IDLE);
  assign accept  = tl.tl_i.a_valid && a_ready;

`ifdef TLUL_ADAPTER_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CntW-1:0] tmo_cnt;
`else
  logic unused_tmo;
  assign unused_tmo = TIMEOUT_CYC[0];
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      is_get   <= 1'b0;
      addr_o   <= '0;
      wdata_o  <= '0;
      be_o     <= '0;
      d_opcode <= '0;
      d_size   <= '0;
      d_source <= '0;
      d_data   <= '0;
      d_error  <= 1'b0;
`ifdef TLUL_ADAPTER_TIMEOUT_EN
      tmo_cnt  <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            is_get   <= (tl.tl_i.a_opcode == Get);
            addr_o   <= tl.tl_i.a_address[REG_AW-1:0];
            wdata_o  <= tl.tl_i.a_data;
            be_o     <= tl.tl_i.a_mask;
            d_size   <= tl.tl_i.a_size;
            d_source <= tl.tl_i.a_source;
            // Only a legal Get returns data; an illegal Get-coded request is a plain ack.
            d_opcode <= ((tl.tl_i.a_opcode == Get) && !illegal) ? AccessAckData : AccessAck;
            d_data   <= '0;
            d_error  <= illegal;
            state    <= illegal ? RSP : REQ;
`ifdef TLUL_ADAPTER_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end
        end
        REQ: begin
          if (ack_i) begin
            d_error <= err_i;
            d_data  <= (is_get && !err_i) ? rdata_i : '0;
            state   <= RSP;
`ifdef TLUL_ADAPTER_TIMEOUT_EN
          end else if (tmo_cnt == CntW'(TIMEOUT_CYC - 1)) begin
            d_error <= 1'b1;
            d_data  <= '0;
            state   <= RSP;
          end else begin
            tmo_cnt <= tmo_cnt + CntW'(1);
`endif
          end
        end
        RSP: begin
          if (tl.tl_i.d_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign re_o = (state == REQ) && is_get;
  assign we_o = (state == REQ) && !is_get;

  always_comb begin
    tl.tl_o          = '0;
    tl.tl_o.d_valid  = (state == RSP);
    tl.tl_o.d_opcode = d_opcode;
    tl.tl_o.d_size   = d_size;
    tl.tl_o.d_source = d_source;
    tl.tl_o.d_data   = d_data;
    tl.tl_o.d_error  = d_error;
    tl.tl_o.a_ready  = a_ready;
  end

  logic unused_a;
  assign unused_a = ^{tl.tl_i.a_param, tl.tl_i.a_address};

endmodule

// File: tb/tb_tlul_adapter_reg.sv
// Directed self-checking bench for tlul_adapter_reg.
module tb_tlul_adapter_reg;
  import tlul_pkg::*;

  logic        clk;
  logic        rst_ni;
  logic        re_o, we_o;
  logic [7:0]  addr_o;
  logic [31:0] wdata_o;
  logic [3:0]  be_o;
  logic [31:0] rdata_i;
  logic        ack_i, err_i;
  int          total, bad;

  tlul_adapter_reg_if tl_if ();

  tlul_adapter_reg #(.REG_AW(8), .TIMEOUT_CYC(8)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .tl      (tl_if),
    .re_o    (re_o),
    .we_o    (we_o),
    .addr_o  (addr_o),
    .wdata_o (wdata_o),
    .be_o    (be_o),
    .rdata_i (rdata_i),
    .ack_i   (ack_i),
    .err_i   (err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request from a negedge with a_ready high and follow it to completion.
  task automatic xact(input string tag, input logic [2:0] op, input logic [31:0] addr,
                      input logic [1:0] size, input logic [7:0] src, input logic [3:0] mask,
                      input logic [31:0] data, input int ack_at, input logic err,
                      input logic [31:0] rdata, input int exp_re, input int exp_we,
                      input logic [2:0] exp_dop, input logic exp_err,
                      input logic [31:0] exp_data, input int stall);
    int nre, nwe, cyc;
    tl_d2h_t snap;
    nre = 0; nwe = 0;
    chk({tag, "_ardy"}, 64'(tl_if.tl_o.a_ready), 64'(1));
    tl_if.tl_i.a_valid   = 1'b1;
    tl_if.tl_i.a_opcode  = op;
    tl_if.tl_i.a_param   = 3'd0;
    tl_if.tl_i.a_size    = size;
    tl_if.tl_i.a_source  = src;
    tl_if.tl_i.a_address = addr;
    tl_if.tl_i.a_mask    = mask;
    tl_if.tl_i.a_data    = data;
    tl_if.tl_i.d_ready   = (stall == 0);
    err_i   = err;
    rdata_i = rdata;
    @(negedge clk);
    tl_if.tl_i.a_valid = 1'b0;
    cyc = 1;
    if (exp_re + exp_we > 0) begin
      chk({tag, "_addr"}, 64'(addr_o), 64'(addr[7:0]));
      chk({tag, "_be"}, 64'(be_o), 64'(mask));
      chk({tag, "_wdata"}, 64'(wdata_o), 64'(data));
    end
    while (!tl_if.tl_o.d_valid && cyc <= 40) begin
      nre += int'(re_o);
      nwe += int'(we_o);
      ack_i = (cyc == ack_at);
      @(negedge clk);
      cyc++;
      ack_i = 1'b0;
    end
    chk({tag, "_dvalid"}, 64'(tl_if.tl_o.d_valid), 64'(1));
    chk({tag, "_lat"}, 64'(cyc), 64'(exp_re + exp_we + 1));
    chk({tag, "_nre"}, 64'(nre), 64'(exp_re));
    chk({tag, "_nwe"}, 64'(nwe), 64'(exp_we));
    chk({tag, "_dop"}, 64'(tl_if.tl_o.d_opcode), 64'(exp_dop));
    chk({tag, "_derr"}, 64'(tl_if.tl_o.d_error), 64'(exp_err));
    chk({tag, "_ddata"}, 64'(tl_if.tl_o.d_data), 64'(exp_data));
    chk({tag, "_dsrc"}, 64'(tl_if.tl_o.d_source), 64'(src));
    chk({tag, "_dsize"}, 64'(tl_if.tl_o.d_size), 64'(size));
    chk({tag, "_dparam_sink"}, 64'({tl_if.tl_o.d_param, tl_if.tl_o.d_sink}), 64'(0));
    chk({tag, "_strobe_off"}, 64'({re_o, we_o, tl_if.tl_o.a_ready}), 64'(0));
    snap = tl_if.tl_o;
    // While stalled, a late ack with different data and a pending request must be ignored.
    for (int i = 0; i < stall; i++) begin
      ack_i = 1'b1;
      rdata_i = ~rdata;
      err_i = ~err;
      tl_if.tl_i.a_valid = 1'b1;
      @(negedge clk);
      chk({tag, "_stable"}, 64'(tl_if.tl_o), 64'(snap));
    end
    tl_if.tl_i.d_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done"}, 64'({tl_if.tl_o.d_valid, re_o, we_o, tl_if.tl_o.a_ready}), 64'(4'b0001));
    tl_if.tl_i.a_valid = 1'b0;
    if (stall > 0) begin
      @(negedge clk);
      chk({tag, "_late_ack_idle"}, 64'({tl_if.tl_o.d_valid, re_o, we_o}), 64'(0));
    end
    ack_i = 1'b0;
    err_i = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_ni = 1'b0;
    ack_i = 1'b0; err_i = 1'b0; rdata_i = '0;
    tl_if.tl_i = '0;
    tl_if.tl_i.d_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ardy", 64'(tl_if.tl_o.a_ready), 64'(0));
    chk("rst_dvalid", 64'(tl_if.tl_o.d_valid), 64'(0));
    chk("rst_strobes", 64'({re_o, we_o}), 64'(0));
    chk("rst_latched", 64'({addr_o, wdata_o, be_o}), 64'(0));
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_rel_ardy", 64'(tl_if.tl_o.a_ready), 64'(1));

    //      tag           op    addr          sz src mask  data          ack err rdata         re we dop derr exp_data      stall
    xact("get10",         3'd4, 32'h10,       2, 3,  4'hF, 32'h0,        3,  0,  32'hDEADBEEF, 3, 0, 1, 0,   32'hDEADBEEF, 0);
    xact("putfull04",     3'd0, 32'h04,       2, 7,  4'hF, 32'h12345678, 1,  0,  32'hAAAA5555, 0, 1, 0, 0,   32'h0,        0);
    xact("op3",           3'd3, 32'h08,       2, 1,  4'hF, 32'h0,        1,  0,  32'h11111111, 0, 0, 0, 1,   32'h0,        0);
    xact("get_misalign",  3'd4, 32'h02,       2, 2,  4'hF, 32'h0,        1,  0,  32'h22222222, 0, 0, 0, 1,   32'h0,        0);
    xact("putpart21",     3'd1, 32'h21,       0, 9,  4'h2, 32'h0000AB00, 2,  0,  32'h0,        0, 2, 0, 0,   32'h0,        0);
    xact("put_mask0",     3'd1, 32'h20,       2, 4,  4'h0, 32'h1,        1,  0,  32'h0,        0, 0, 0, 1,   32'h0,        0);
    xact("putfull_mask7", 3'd0, 32'h20,       2, 4,  4'h7, 32'h1,        1,  0,  32'h0,        0, 0, 0, 1,   32'h0,        0);
    xact("get_size3",     3'd4, 32'h00,       3, 5,  4'hF, 32'h0,        1,  0,  32'h33333333, 0, 0, 0, 1,   32'h0,        0);
    xact("get_hw_odd",    3'd4, 32'h03,       1, 5,  4'hC, 32'h0,        1,  0,  32'h33333333, 0, 0, 0, 1,   32'h0,        0);
    xact("get_err",       3'd4, 32'h0C,       2, 6,  4'hF, 32'h0,        2,  1,  32'h44444444, 2, 0, 1, 1,   32'h0,        0);
    xact("get_stall",     3'd4, 32'h30,       2, 8,  4'hF, 32'h0,        1,  0,  32'hCAFEF00D, 1, 0, 1, 0,   32'hCAFEF00D, 5);
    xact("get_hiaddr",    3'd4, 32'h12345678, 2, 10, 4'hF, 32'h0,        1,  0,  32'h0BADF00D, 1, 0, 1, 0,   32'h0BADF00D, 0);
`ifdef TLUL_ADAPTER_TIMEOUT_EN
    xact("get_timeout",   3'd4, 32'h40,       2, 11, 4'hF, 32'h0,        0,  0,  32'h66666666, 8, 0, 1, 1,   32'h0,        2);
`endif

    // Reset while a Get is waiting for its ack.
    tl_if.tl_i.a_valid   = 1'b1;
    tl_if.tl_i.a_opcode  = 3'd4;
    tl_if.tl_i.a_size    = 2'd2;
    tl_if.tl_i.a_address = 32'h50;
    tl_if.tl_i.a_mask    = 4'hF;
    @(negedge clk);
    tl_if.tl_i.a_valid = 1'b0;
    chk("midrst_re_before", 64'(re_o), 64'(1));
    rst_ni = 1'b0;
    @(negedge clk);
    chk("midrst_out", 64'({re_o, we_o, tl_if.tl_o.d_valid, tl_if.tl_o.a_ready}), 64'(0));
    rst_ni = 1'b1;
    @(negedge clk);
    xact("get_after_rst", 3'd4, 32'h54,       2, 12, 4'hF, 32'h0,        1,  0,  32'h76543210, 1, 0, 1, 0,   32'h76543210, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
